// File: rtl/axi4_s_bus_rd_fifos_cr_pkg.sv
// Shared types and helpers for the AXI4 slave read-channel buffer.
// Payload struct widths follow the package defaults, which the top-level parameters default to.
package axi4_s_bus_rd_fifos_cr_pkg;

  localparam int AXI_A = 32;
  localparam int AXI_N = 8;
  localparam int AXI_I = 1;

  typedef struct packed {
    logic [AXI_I-1:0] id;
    logic [AXI_A-1:0] addr;
    logic [7:0]       len;
  } ar_t;

  typedef struct packed {
    logic [AXI_I-1:0]   id;
    logic [8*AXI_N-1:0] data;
    logic               last;
    logic [1:0]         resp;
  } r_t;

  // Beats a burst reserves: arlen+1 without wrap, capped at the R FIFO depth.
  function automatic int unsigned beats_need(input logic [7:0] len, input int unsigned depth);
    int unsigned beats;
    beats = 32'(len) + 32'd1;
    return (beats > depth) ? depth : beats;
  endfunction

endpackage

// File: rtl/axi4_s_bus_rd_fifos_cr_if.sv
// Slave-side AXI4 AR/R channel bundle; the buffer uses the slave modport.
interface axi4_s_bus_rd_fifos_cr_if #(
  parameter int A = 32,
  parameter int N = 8,
  parameter int I = 1
);
  logic           arvalid;
  logic           arready;
  logic [I-1:0]   arid;
  logic [A-1:0]   araddr;
  logic [7:0]     arlen;
  logic           rvalid;
  logic           rready;
  logic [I-1:0]   rid;
  logic [8*N-1:0] rdata;
  logic           rlast;
  logic [1:0]     rresp;

  modport slave (
    input  arvalid, arid, araddr, arlen, rready,
    output arready, rvalid, rid, rdata, rlast, rresp
  );

  modport master (
    output arvalid, arid, araddr, arlen, rready,
    input  arready, rvalid, rid, rdata, rlast, rresp
  );
endinterface

// File: rtl/axi4_s_bus_rd_fifos_cr_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; full is judged before any same-cycle pop.
module sync_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [W-1:0]           din,
  input  logic                   rd_en,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(D+1)-1:0] count
);
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D+1);

  logic [PW:0]  wp;
  logic [PW:0]  rp;
  logic [W-1:0] mem [D];
  logic         push;
  logic         pop;

  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign count = CW'(wp - rp);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;
  assign dout  = mem[rp[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[PW-1:0]] <= din;
  end

endmodule

// File: rtl/axi4_s_bus_rd_fifos_cr.sv
// AXI4 slave read-channel buffer: AR and R FIFOs plus burst-credit admission so
// backend R writes for accepted bursts always have room.
module axi4_s_bus_rd_fifos_cr
  import axi4_s_bus_rd_fifos_cr_pkg::*;
#(
  parameter int A    = AXI_A,
  parameter int N    = AXI_N,
  parameter int I    = AXI_I,
  parameter int AR_D = 4,
  parameter int R_D  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  axi4_s_bus_rd_fifos_cr_if.slave   s_axi,
  input  logic                      ar_rd_en,
  output logic                      ar_rd_empty,
  output logic [I-1:0]              ar_rd_id,
  output logic [A-1:0]              ar_rd_addr,
  output logic [7:0]                ar_rd_len,
  input  logic                      r_wr_en,
  input  logic [I-1:0]              r_wr_id,
  input  logic [8*N-1:0]            r_wr_data,
  input  logic                      r_wr_last,
  input  logic [1:0]                r_wr_resp,
  output logic [$clog2(AR_D+1)-1:0] ar_count,
  output logic [$clog2(R_D+1)-1:0]  r_count,
  output logic [$clog2(R_D+1)-1:0]  credits,
  output logic                      len_err,
  output logic                      r_ovf
);
  localparam int CW = $clog2(R_D+1);

  ar_t           ar_in;
  ar_t           ar_out;
  r_t            r_in;
  r_t            r_out;
  logic          ar_full;
  logic          r_full;
  logic          r_empty;
  logic          arready_i;
  logic          ar_hs;
  logic          r_hs;
  logic          oversize;
  logic [CW-1:0] need;
  logic [CW-1:0] credits_q;
  logic [CW-1:0] credits_nxt;
  logic [CW:0]   credits_sum;

  assign ar_in.id   = s_axi.arid;
  assign ar_in.addr = s_axi.araddr;
  assign ar_in.len  = s_axi.arlen;

  assign r_in.id   = r_wr_id;
  assign r_in.data = r_wr_data;
  assign r_in.last = r_wr_last;
  assign r_in.resp = r_wr_resp;

  assign need     = CW'(beats_need(s_axi.arlen, R_D));
  assign oversize = (32'(s_axi.arlen) + 32'd1) > 32'(R_D);

  // Admission looks only at registered credits; a same-cycle release helps next cycle.
  assign arready_i = !reset && !ar_full && (credits_q >= need);
  assign ar_hs     = s_axi.arvalid && arready_i;
  assign r_hs      = !r_empty && s_axi.rready;

  always_comb begin
    credits_sum = {1'b0, credits_q};
    if (ar_hs) credits_sum = credits_sum - {1'b0, need};
    if (r_hs)  credits_sum = credits_sum + 1'b1;
    credits_nxt = (credits_sum > (CW+1)'(R_D)) ? CW'(R_D) : credits_sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q <= CW'(R_D);
      len_err   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      credits_q <= credits_nxt;
      if (ar_hs && oversize) len_err <= 1'b1;
      if (r_wr_en && r_full) r_ovf   <= 1'b1;
    end
  end

  sync_fifo #(.W($bits(ar_t)), .D(AR_D)) u_ar_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (ar_hs),
    .din   (ar_in),
    .rd_en (ar_rd_en),
    .dout  (ar_out),
    .full  (ar_full),
    .empty (ar_rd_empty),
    .count (ar_count)
  );

  sync_fifo #(.W($bits(r_t)), .D(R_D)) u_r_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (r_wr_en),
    .din   (r_in),
    .rd_en (s_axi.rready),
    .dout  (r_out),
    .full  (r_full),
    .empty (r_empty),
    .count (r_count)
  );

  assign s_axi.arready = arready_i;
  assign s_axi.rvalid  = !r_empty;
  assign s_axi.rid     = r_out.id;
  assign s_axi.rdata   = r_out.data;
  assign s_axi.rlast   = r_out.last;
  assign s_axi.rresp   = r_out.resp;

  assign ar_rd_id   = ar_out.id;
  assign ar_rd_addr = ar_out.addr;
  assign ar_rd_len  = ar_out.len;
  assign credits    = credits_q;

endmodule

// File: tb/tb_axi4_s_bus_rd_fifos_cr.sv
// Randomised scoreboard bench for the AXI4 read-channel buffer with a queue-based credit model.
module tb_axi4_s_bus_rd_fifos_cr;
  localparam int A    = 32;
  localparam int N    = 8;
  localparam int I    = 1;
  localparam int AR_D = 4;
  localparam int R_D  = 16;

  typedef struct {
    int unsigned     id;
    int unsigned     addr;
    int unsigned     len;
  } ar_item_t;

  typedef struct {
    int unsigned     id;
    longint unsigned data;
    int unsigned     last;
    int unsigned     resp;
  } r_item_t;

  logic clk = 1'b0;
  logic reset;
  logic ar_rd_en;
  logic ar_rd_empty;
  logic [I-1:0] ar_rd_id;
  logic [A-1:0] ar_rd_addr;
  logic [7:0] ar_rd_len;
  logic r_wr_en;
  logic [I-1:0] r_wr_id;
  logic [8*N-1:0] r_wr_data;
  logic r_wr_last;
  logic [1:0] r_wr_resp;
  logic [$clog2(AR_D+1)-1:0] ar_count;
  logic [$clog2(R_D+1)-1:0] r_count;
  logic [$clog2(R_D+1)-1:0] credits;
  logic len_err;
  logic r_ovf;

  axi4_s_bus_rd_fifos_cr_if #(.A(A), .N(N), .I(I)) bus ();

  axi4_s_bus_rd_fifos_cr #(.A(A), .N(N), .I(I), .AR_D(AR_D), .R_D(R_D)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_axi       (bus),
    .ar_rd_en    (ar_rd_en),
    .ar_rd_empty (ar_rd_empty),
    .ar_rd_id    (ar_rd_id),
    .ar_rd_addr  (ar_rd_addr),
    .ar_rd_len   (ar_rd_len),
    .r_wr_en     (r_wr_en),
    .r_wr_id     (r_wr_id),
    .r_wr_data   (r_wr_data),
    .r_wr_last   (r_wr_last),
    .r_wr_resp   (r_wr_resp),
    .ar_count    (ar_count),
    .r_count     (r_count),
    .credits     (credits),
    .len_err     (len_err),
    .r_ovf       (r_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain queues for FIFO contents plus an integer credit pool.
  ar_item_t ar_q[$];
  r_item_t  r_q[$];
  int       credits_m;
  bit       len_err_m;
  bit       r_ovf_m;
  bit       model_live = 1'b0;

  always @(negedge clk) begin
    int       need_m;
    int       c;
    bit       exp_ardy;
    bit       ar_hs_m;
    bit       r_hs_m;
    bit       rfull_pre;
    ar_item_t a;
    r_item_t  r;
    need_m = int'(bus.arlen) + 1;
    if (need_m > R_D) need_m = R_D;
    exp_ardy = !reset && (ar_q.size() < AR_D) && (credits_m >= need_m);
    if (model_live) begin
      chk("arready", 64'(bus.arready), 64'(exp_ardy));
      chk("ar_count", 64'(ar_count), 64'(ar_q.size()));
      chk("r_count", 64'(r_count), 64'(r_q.size()));
      chk("credits", 64'(credits), 64'(credits_m));
      chk("ar_rd_empty", 64'(ar_rd_empty), 64'(ar_q.size() == 0));
      chk("rvalid", 64'(bus.rvalid), 64'(r_q.size() != 0));
      chk("len_err", 64'(len_err), 64'(len_err_m));
      chk("r_ovf", 64'(r_ovf), 64'(r_ovf_m));
      if (ar_rd_en && ar_q.size() > 0) begin
        chk("ar_rd_id", 64'(ar_rd_id), 64'(ar_q[0].id));
        chk("ar_rd_addr", 64'(ar_rd_addr), 64'(ar_q[0].addr));
        chk("ar_rd_len", 64'(ar_rd_len), 64'(ar_q[0].len));
      end
      if (bus.rready && r_q.size() > 0) begin
        chk("rid", 64'(bus.rid), 64'(r_q[0].id));
        chk("rdata", 64'(bus.rdata), r_q[0].data);
        chk("rlast", 64'(bus.rlast), 64'(r_q[0].last));
        chk("rresp", 64'(bus.rresp), 64'(r_q[0].resp));
      end
    end
    if (reset) begin
      ar_q.delete();
      r_q.delete();
      credits_m  = R_D;
      len_err_m  = 1'b0;
      r_ovf_m    = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      ar_hs_m   = bus.arvalid && exp_ardy;
      r_hs_m    = (r_q.size() > 0) && bus.rready;
      rfull_pre = (r_q.size() == R_D);
      if (ar_rd_en && ar_q.size() > 0) void'(ar_q.pop_front());
      if (ar_hs_m) begin
        a.id = bus.arid; a.addr = bus.araddr; a.len = bus.arlen;
        ar_q.push_back(a);
        if (int'(bus.arlen) + 1 > R_D) len_err_m = 1'b1;
      end
      if (r_hs_m) void'(r_q.pop_front());
      if (r_wr_en) begin
        if (rfull_pre) r_ovf_m = 1'b1;
        else begin
          r.id = r_wr_id; r.data = r_wr_data; r.last = r_wr_last; r.resp = r_wr_resp;
          r_q.push_back(r);
        end
      end
      c = credits_m - (ar_hs_m ? need_m : 0) + (r_hs_m ? 1 : 0);
      if (c > R_D) c = R_D;
      credits_m = c;
    end
  end

  // Backend stimulus: only writes beats belonging to bursts it has popped.
  int pend_q[$];
  int beat_i = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_backend(input bit allow_rd, input int wr_pct);
    ar_rd_en = allow_rd;
    if (allow_rd && !ar_rd_empty) pend_q.push_back(int'(ar_rd_len) + 1);
    if (pend_q.size() > 0 && $urandom_range(99) < wr_pct) begin
      r_wr_en   = 1'b1;
      r_wr_id   = 1'($urandom);
      r_wr_data = {$urandom, $urandom};
      r_wr_resp = 2'($urandom);
      r_wr_last = (beat_i == pend_q[0] - 1);
      beat_i++;
      if (r_wr_last) begin
        void'(pend_q.pop_front());
        beat_i = 0;
      end
    end else begin
      r_wr_en = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    while (n < 600 && !(ar_rd_empty && pend_q.size() == 0 && !bus.rvalid)) begin
      drive_backend(1'b1, 100);
      tick();
      n++;
    end
    r_wr_en  = 1'b0;
    ar_rd_en = 1'b0;
    checks++;
    if (n >= 600) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles required under 600", n);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    ar_rd_en = 1'b0; r_wr_en = 1'b0;
    pend_q.delete();
    beat_i = 0;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.rready = 1'b0;
    ar_rd_en = 1'b0; r_wr_en = 1'b0; r_wr_id = '0; r_wr_data = '0; r_wr_last = 1'b0; r_wr_resp = '0;
    do_reset(3);

    // Credit exhaustion with len=3 bursts, then partial and full drain.
    bus.arvalid = 1'b1; bus.arlen = 8'd3; bus.arid = 1'b0; bus.araddr = 32'h1000;
    for (int k = 0; k < 8; k++) begin
      drive_backend(1'b1, 0);
      tick();
      bus.araddr = bus.araddr + 32'd16;
    end
    bus.rready = 1'b0;
    for (int k = 0; k < 4; k++) begin drive_backend(1'b1, 100); tick(); end
    r_wr_en = 1'b0; ar_rd_en = 1'b0;
    tick();
    bus.rready = 1'b1; tick();
    bus.rready = 1'b0; repeat (2) tick();
    bus.rready = 1'b1;
    for (int k = 0; k < 6; k++) begin drive_backend(1'b1, 100); tick(); end
    drain();

    // Randomised traffic with legal backend behaviour.
    for (int k = 0; k < 1500; k++) begin
      bus.arvalid = 1'($urandom);
      bus.arid    = 1'($urandom);
      bus.araddr  = $urandom;
      bus.arlen   = 8'($urandom_range(15));
      bus.rready  = ($urandom_range(3) != 0);
      drive_backend($urandom_range(3) != 0, 70);
      tick();
    end
    drain();

    // Same-cycle accept (need=2) and pop with five credits left.
    bus.rready = 1'b0;
    bus.arvalid = 1'b1; bus.arlen = 8'd10; bus.araddr = 32'h2000;
    tick();
    bus.arvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin drive_backend(1'b1, 100); tick(); end
    ar_rd_en = 1'b0; r_wr_en = 1'b0;
    bus.arvalid = 1'b1; bus.arlen = 8'd1; bus.araddr = 32'h3000; bus.rready = 1'b1;
    tick();
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    drive_backend(1'b0, 100);
    tick();
    r_wr_en = 1'b0;
    tick();

    // Reset with beats and reservations outstanding.
    do_reset(1);
    repeat (2) tick();

    // Oversized burst: reserves the whole FIFO, 17th beat is dropped.
    bus.arvalid = 1'b1; bus.arlen = 8'd31; bus.araddr = 32'h4000;
    tick();
    bus.arvalid = 1'b0;
    for (int k = 0; k < 17; k++) begin drive_backend(1'b1, 100); tick(); end
    r_wr_en = 1'b0; ar_rd_en = 1'b0;
    tick();
    bus.rready = 1'b1;
    repeat (20) tick();
    do_reset(1);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_s_bus_rd_fifos_cr.md
# axi4_s_bus_rd_fifos_cr

Parametrised AXI4 slave-side read-channel buffer with burst-credit admission control. It sits between an AXI4 slave port and a backend read engine, and buffers AR requests and R beats in configurable-depth synchronous FIFOs. An AR burst is accepted only when the R FIFO has unreserved space for every beat of that burst, so backend R writes never stall and never overflow under legal use. Occupancy, credit and error status are exported for performance counters and debug.

## Interface
- A, 32, address width
- N, 8, data bytes per beat; R data width 8*N
- I, 1, ID width
- AR_D, 4, AR FIFO depth (power of two, ≥2)
- R_D, 16, R FIFO depth in beats (power of two, ≥2)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- arvalid, arready  in/out  1  slave AR handshake
- arid, araddr, arlen  in  I, A, 8  AR payload
- rvalid, rready  out/in  1  slave R handshake
- rid, rdata, rlast, rresp  out  I, 8N, 1, 2  R payload
- ar_rd_en  in  1  backend pops AR head
- ar_rd_empty  out  1  AR FIFO empty
- ar_rd_id, ar_rd_addr, ar_rd_len  out  I, A, 8  AR head (valid when !ar_rd_empty)
- r_wr_en  in  1  backend pushes one R beat
- r_wr_id, r_wr_data, r_wr_last, r_wr_resp  in  I, 8N, 1, 2  R beat
- ar_count  out  $clog2(AR_D+1)  AR FIFO occupancy
- r_count  out  $clog2(R_D+1)  R FIFO occupancy
- credits  out  $clog2(R_D+1)  unreserved R beats
- len_err  out  1  sticky: burst accepted with arlen+1 > R_D
- r_ovf  out  1  sticky: r_wr_en while R FIFO full (beat dropped)

## Operation
- beats = arlen+1 (9-bit arithmetic, no wrap).
- need = min(beats, R_D).
- arready = !reset && !ar_full && (credits ≥ need).
- On AR handshake: push {arid, araddr, arlen}; credits -= need; if beats > R_D, set len_err.
- Oversized bursts wait until credits == R_D and reserve the whole FIFO. Their excess beats are the backend's fault and are counted by r_ovf.
- rvalid = !r_empty; R payload = R FIFO head.
- On R handshake (rvalid && rready): pop; credits += 1, saturating at R_D.
- credits update in one step: credits_next = credits − (ar_hs ? need : 0) + (r_hs ? 1 : 0). The credit check uses the registered credits, so a same-cycle release is not visible to arready until the next cycle.
- ar_rd_en while ar_rd_empty: ignored.
- r_wr_en while r_full: beat dropped, r_ovf set, credits unchanged.
- Simultaneous push and pop on a full FIFO: the pop proceeds. The push is blocked (full is evaluated pre-pop).
- No reordering, no ID interleave handling; R order equals backend write order.
- len_err and r_ovf clear only on reset.

## Timing
- Reset values:
  - FIFOs empty; ar_count = r_count = 0; credits = R_D.
  - arready = 0 while reset is high; rvalid = 0.
  - ar_rd_empty = 1; len_err = r_ovf = 0.
  - Payload outputs are don't-care (zero preferred).
- arready = 1 in the first cycle after reset falls (FIFOs empty, full credits).
- AR accepted in cycle n: ar_rd_empty falls in n+1, and ar_count/credits reflect it in n+1.
- R written in cycle n: rvalid rises in n+1.
- Pop to not-full is seen by the writer in the next cycle.
- Sustained 1 AR/cycle and 1 R beat/cycle throughput when not full/empty.
- Reset mid-burst: all state discarded in the cycle it is sampled, including reservations. Upstream and backend must also reset.

## Structure
- Package axi4_s_bus_rd_fifos_cr_pkg:
  - ar_t struct {id, addr, len}
  - r_t struct {id, data, last, resp}
  - helper function beats_need(len, R_D)
- Sub-module sync_fifo #(W, D):
  - registered storage, ptr+1-bit full/empty, count output
  - instantiated twice (ar_t, r_t)
- Credit counter and sticky flags live in the top module.

## Test plan
- Reset, then AR len=3 with R_D=16 → arready=1; credits 16→12 next cycle; ar_rd_empty falls next cycle; ar_rd_len=3.
- Four AR len=3 back-to-back → credits reach 0, fifth AR held arready=0. Pop one R beat → arready=1 only if need ≤ 1, else still 0 until 4 beats are drained.
- Backend writes 4 beats, slave holds rready=0 then 1 → rdata in order, rlast on beat 4, credits returns +4 over 4 cycles.
- AR len=31 (R_D=16) → waits for credits=16; accepts; len_err=1; credits=0. The 17th r_wr_en without a pop → r_ovf=1, beat dropped.
- Same-cycle AR handshake (need=2) and R pop with credits=5 → credits=4 next cycle.
- Assert reset mid-burst with r_count=3 → next cycle r_count=0, credits=R_D, rvalid=0, flags clear.
